// File: rtl/fir_tap_seq_pkg.sv
// Shared definitions for the FIR tap sequencer: state encoding, default tap
// count, accumulator width rule and the multiplier latency.
package fir_tap_seq_pkg;

  // state    | meaning
  // ST_IDLE  | waiting for a sample, coefficient writes allowed
  // ST_RUN   | issuing one tap per cycle to the multiplier
  // ST_DRAIN | waiting MUL_LAT cycles for the last products to return
  // ST_DONE  | result presented for one cycle, next sample may be taken
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int TAPS_DEF = 4;
  localparam int SAMPLE_W = 8;

  // Fixed latency of the external multiplier: sizes the product valid pipe
  // and the number of DRAIN cycles.
  localparam int MUL_LAT = 2;

  // Smallest accumulator that can hold TAPS truncated 8-bit products.
  function automatic int acc_w_min(input int taps);
    return SAMPLE_W + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_tap_regs.sv
// Sample history shift register and coefficient bank with a shared read index.
module fir_tap_regs
  import fir_tap_seq_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_shift,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_coef_we,
  input  logic [AW-1:0]       i_coef_addr,
  input  logic [SAMPLE_W-1:0] i_coef_data,
  input  logic [AW-1:0]       i_rd_idx,
  output logic [SAMPLE_W-1:0] o_hist,
  output logic [SAMPLE_W-1:0] o_coef
);

  logic [SAMPLE_W-1:0] r_hist [TAPS];
  logic [SAMPLE_W-1:0] r_coef [TAPS];

  // On an accepted sample the newest value enters slot 0 and the rest age by one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) r_hist[k] <= '0;
    end else if (i_shift) begin
      r_hist[0] <= i_sample;
      for (int k = 1; k < TAPS; k++) r_hist[k] <= r_hist[k-1];
    end
  end

  // Coefficient write; addresses beyond TAPS-1 (non power-of-two TAPS) match no slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) r_coef[k] <= '0;
    end else if (i_coef_we) begin
      for (int k = 0; k < TAPS; k++) begin
        if (i_coef_addr == AW'(k)) r_coef[k] <= i_coef_data;
      end
    end
  end

  // Indexed read of the sample/coefficient pair for the current tap.
  always_comb begin
    o_hist = '0;
    o_coef = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (i_rd_idx == AW'(k)) begin
        o_hist = r_hist[k];
        o_coef = r_coef[k];
      end
    end
  end

endmodule

// File: rtl/fir_tap_seq.sv
// FIR tap sequencer: takes one sample, issues TAPS multiplies to the external
// 2-cycle multiplier, sums the returned products and emits one result.
module fir_tap_seq
  import fir_tap_seq_pkg::*;
#(
  parameter int TAPS  = TAPS_DEF,
  parameter int ACC_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [7:0]              coef_data,
  output logic                    mul_en,
  output logic [7:0]              mul_a,
  output logic [7:0]              mul_b,
  input  logic [7:0]              mul_p,
  output logic                    out_valid,
  output logic [ACC_W-1:0]        out_data
);

  localparam int AW = $clog2(TAPS);
  localparam int DW = $clog2(MUL_LAT + 1);

  if (ACC_W < acc_w_min(TAPS)) begin : g_acc_w_check
    $error("fir_tap_seq: ACC_W too small for TAPS");
  end

  state_t               r_state;
  state_t               w_next_state;
  logic [AW-1:0]        r_tap;
  logic [DW-1:0]        r_drain_cnt;
  logic [MUL_LAT-1:0]   r_vpipe;
  logic [ACC_W-1:0]     r_acc;
  logic [ACC_W-1:0]     r_out_data;
  logic [ACC_W-1:0]     w_acc_next;
  logic [SAMPLE_W-1:0]  w_hist_rd;
  logic [SAMPLE_W-1:0]  w_coef_rd;
  logic                 w_accept;
  logic                 w_last_tap;
  logic                 w_drain_end;

  assign w_accept    = in_ready & in_valid;
  assign w_last_tap  = (r_tap == AW'(TAPS - 1));
  assign w_drain_end = (r_drain_cnt == '0);
  // Product returning this cycle belongs to a tap issued MUL_LAT cycles ago.
  assign w_acc_next  = r_vpipe[MUL_LAT-1] ? (r_acc + ACC_W'(mul_p)) : r_acc;
  assign out_data    = r_out_data;

  fir_tap_regs #(
    .TAPS (TAPS),
    .AW   (AW)
  ) u_regs (
    .clk         (clk),
    .reset       (reset),
    .i_shift     (w_accept),
    .i_sample    (in_data),
    .i_coef_we   (coef_we & in_ready),
    .i_coef_addr (coef_addr),
    .i_coef_data (coef_data),
    .i_rd_idx    (r_tap),
    .o_hist      (w_hist_rd),
    .o_coef      (w_coef_rd)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode; DONE can chain straight into the next RUN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_next_state = ST_RUN;
      ST_RUN:   if (w_last_tap) w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_drain_end) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = in_valid ? ST_RUN : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; operands are forced to zero outside RUN.
  always_comb begin
    in_ready  = 1'b0;
    mul_en    = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN: begin
        mul_en = 1'b1;
        mul_a  = w_hist_rd;
        mul_b  = w_coef_rd;
      end
      ST_DONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Tap index and DRAIN down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tap       <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_accept)    r_tap <= '0;
      else if (mul_en) r_tap <= w_last_tap ? '0 : r_tap + 1'b1;

      if (mul_en && w_last_tap)                 r_drain_cnt <= DW'(MUL_LAT - 1);
      else if (r_state == ST_DRAIN && !w_drain_end) r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  // Product valid pipe, accumulator and result register. The result is
  // captured on the DRAIN->DONE edge including the last returning product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vpipe    <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else begin
      r_vpipe <= {r_vpipe[MUL_LAT-2:0], mul_en};
      if (w_accept) r_acc <= '0;
      else          r_acc <= w_acc_next;
      if (r_state == ST_DRAIN && w_drain_end) r_out_data <= w_acc_next;
    end
  end

endmodule

// File: tb/tb_fir_tap_seq.sv
// Bench for fir_tap_seq: behavioural multiplier, cycle-level reference model
// of the sequencer timeline, per-cycle compare, directed and random stimulus.
module tb_fir_tap_seq;

  localparam int TAPS     = 4;
  localparam int ACC_W    = 10;
  localparam int AW       = 2;
  localparam int DONE_AGE = TAPS + 3;

  logic             clk       = 1'b0;
  logic             reset     = 1'b0;
  logic             in_valid  = 1'b0;
  logic [7:0]       in_data   = '0;
  logic             coef_we   = 1'b0;
  logic [AW-1:0]    coef_addr = '0;
  logic [7:0]       coef_data = '0;
  logic [7:0]       mul_p     = '0;
  logic             in_ready;
  logic             mul_en;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic             out_valid;
  logic [ACC_W-1:0] out_data;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  fir_tap_seq #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .mul_en    (mul_en),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: exact 2-cycle latency, low 8 bits; junk when idle.
  logic [7:0] mp_d1 = '0;
  always @(posedge clk) begin
    mp_d1 <= mul_en ? 8'((int'(mul_a) * int'(mul_b)) % 256) : 8'($urandom);
    mul_p <= mp_d1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_age counts cycles since the accepting edge
  // (0 = idle, 1..TAPS = tap issue, DONE_AGE = result cycle).
  int m_hist [TAPS];
  int m_coef [TAPS];
  int m_age  = 0;
  int m_pend = 0;
  int m_out  = 0;

  function automatic bit m_ready();
    return (m_age == 0) || (m_age == DONE_AGE);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      m_hist[k] = 0;
      m_coef[k] = 0;
    end
    m_age  = 0;
    m_pend = 0;
    m_out  = 0;
  endtask

  task automatic model_step();
    bit rdy;
    int s;
    rdy = m_ready();
    if (rdy && coef_we) m_coef[coef_addr] = int'(coef_data);
    if (rdy && in_valid) begin
      for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = int'(in_data);
      s = 0;
      for (int k = 0; k < TAPS; k++) s += (m_hist[k] * m_coef[k]) % 256;
      m_pend = s % (1 << ACC_W);
      m_age  = 1;
    end else if (m_age == DONE_AGE) begin
      m_age = 0;
    end else if (m_age > 0) begin
      m_age++;
      if (m_age == DONE_AGE) m_out = m_pend;
    end
  endtask

  // Advance the model with the same clock/reset the DUT sees.
  always @(posedge clk or negedge reset) begin
    if (!reset) model_clear();
    else        model_step();
  end

  task automatic compare_cycle();
    int ea;
    int eb;
    int en;
    en = (m_age >= 1 && m_age <= TAPS) ? 1 : 0;
    ea = 0;
    eb = 0;
    if (en == 1) begin
      ea = m_hist[m_age-1];
      eb = m_coef[m_age-1];
    end
    chk("in_ready",  int'(in_ready),  int'(m_ready()));
    chk("mul_en",    int'(mul_en),    en);
    chk("mul_a",     int'(mul_a),     ea);
    chk("mul_b",     int'(mul_b),     eb);
    chk("out_valid", int'(out_valid), (m_age == DONE_AGE) ? 1 : 0);
    chk("out_data",  int'(out_data),  m_out);
  endtask

  // Per-cycle compare, sampled away from the active edge.
  always @(negedge clk) compare_cycle();

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = 8'(d);
    sync();
    coef_we   = 1'b0;
  endtask

  // Offer a sample and hold it until the accepting edge; returns cycle 0 index.
  task automatic send(input int s, output int ac);
    bit done;
    bit rdy;
    done     = 1'b0;
    ac       = -1;
    in_valid = 1'b1;
    in_data  = 8'(s);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      rdy = m_ready();
      sync();
      if (rdy) begin
        done = 1'b1;
        ac   = cyc - 1;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_out(output int v, output int c);
    bit got;
    got = 1'b0;
    v   = -1;
    c   = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        v   = int'(out_data);
        c   = cyc;
      end
    end
    if (!got) chk("out_timeout", 0, 1);
    sync();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ac;
    int v;
    int c;
    int acc_cyc [4];
    int pulses;
    int imp_exp [4];

    imp_exp[0] = 1; imp_exp[1] = 2; imp_exp[2] = 3; imp_exp[3] = 4;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_mul_en",    int'(mul_en),    0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  0);
    reset = 1'b1;
    sync();

    // Impulse response
    for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1);
    for (int i = 0; i < 4; i++) begin
      send((i == 0) ? 1 : 0, ac);
      wait_out(v, c);
      chk("impulse_val", v, imp_exp[i]);
      chk("impulse_lat", c - ac, 7);
    end

    // Truncation, with the coef[0] write in the same cycle as the accept
    for (int k = 1; k < TAPS; k++) wr_coef(k, 0);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd3;
    send(200, ac);
    coef_we = 1'b0;
    wait_out(v, c);
    chk("truncation", v, 88);

    // Back-to-back with in_valid held high
    for (int k = 0; k < TAPS; k++) wr_coef(k, int'($urandom_range(0, 255)));
    for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 255)), acc_cyc[i]);
    for (int i = 1; i < 4; i++) chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 7);
    wait_out(v, c);

    // Coefficient write while busy is dropped; the same write when idle lands
    wr_coef(0, 0); wr_coef(1, 5); wr_coef(2, 0); wr_coef(3, 0);
    send(7, ac);
    wr_coef(1, 9);
    wait_out(v, c);
    send(0, ac);
    wait_out(v, c);
    chk("busy_wr_ignored", v, 35);
    wr_coef(1, 9);
    send(3, ac);
    wait_out(v, c);
    send(0, ac);
    wait_out(v, c);
    chk("idle_wr_applied", v, 27);

    // Reset during tap 2
    send(50, ac);
    sync();
    sync();
    #1 reset = 1'b0;
    #1;
    chk("rst_run_mul_en",    int'(mul_en),    0);
    chk("rst_run_mul_a",     int'(mul_a),     0);
    chk("rst_run_mul_b",     int'(mul_b),     0);
    chk("rst_run_out_valid", int'(out_valid), 0);
    chk("rst_run_out_data",  int'(out_data),  0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("rst_no_out_valid", pulses, 0);
    sync();
    for (int k = 0; k < TAPS; k++) wr_coef(k, 1);
    send(10, ac);
    wait_out(v, c);
    chk("rst_zero_hist", v, 10);

    // Full-scale
    for (int k = 0; k < TAPS; k++) wr_coef(k, 255);
    for (int i = 0; i < 4; i++) begin
      send(255, ac);
      wait_out(v, c);
    end
    chk("full_scale", v, 4);

    // Random traffic, including writes while busy and same-cycle write/accept
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      in_data   = 8'($urandom);
      coef_we   = ($urandom_range(0, 3) == 0);
      coef_addr = AW'($urandom);
      coef_data = 8'($urandom);
      sync();
    end
    in_valid = 1'b0;
    coef_we  = 1'b0;
    repeat (12) sync();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
